// File: rtl/id_issue_if.sv
// Decoder, EX and WB signals seen by the ID issue controller, plus its decisions and status.
interface id_issue_if;
    logic        id_valid_i;
    logic [4:0]  id_rs1_idx_i;
    logic [4:0]  id_rs2_idx_i;
    logic        id_rs1_ren_i;
    logic        id_rs2_ren_i;
    logic [4:0]  id_rd_idx_i;
    logic        id_rd_wen_i;
    logic        id_long_lat_i;
    logic        id_serial_i;
    logic        ex_ready_i;
    logic        ex_flush_i;
    logic        wb_valid_i;
    logic        wb_rd_wen_i;
    logic        wb_long_lat_i;
    logic [4:0]  wb_rd_idx_i;
    logic        id_issue_o;
    logic        id_stall_o;
    logic [31:0] sb_busy_o;
    logic [2:0]  inflight_o;
    logic [1:0]  state_o;
    logic        err_o;

    modport slave (
        input  id_valid_i, id_rs1_idx_i, id_rs2_idx_i, id_rs1_ren_i, id_rs2_ren_i,
               id_rd_idx_i, id_rd_wen_i, id_long_lat_i, id_serial_i,
               ex_ready_i, ex_flush_i,
               wb_valid_i, wb_rd_wen_i, wb_long_lat_i, wb_rd_idx_i,
        output id_issue_o, id_stall_o, sb_busy_o, inflight_o, state_o, err_o
    );

    modport master (
        output id_valid_i, id_rs1_idx_i, id_rs2_idx_i, id_rs1_ren_i, id_rs2_ren_i,
               id_rd_idx_i, id_rd_wen_i, id_long_lat_i, id_serial_i,
               ex_ready_i, ex_flush_i,
               wb_valid_i, wb_rd_wen_i, wb_long_lat_i, wb_rd_idx_i,
        input  id_issue_o, id_stall_o, sb_busy_o, inflight_o, state_o, err_o
    );
endinterface

// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: long-latency scoreboard, in-flight counting and
// serialization of system/CSR instructions.
module id_issue_ctrl #(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic       clk,
    input  logic       rst,
    id_issue_if.slave  bus
);
    localparam int unsigned NREG  = 32;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SERIAL = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NREG-1:0]  sb_q, sb_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;

    logic [NREG-1:0]  rel_mask, set_mask, eff_sb;
    logic             rel, hazard, room, cnt_zero, retire, issue_c;

    // Release is visible to the hazard check in the same cycle it arrives.
    always_comb begin
        rel      = bus.wb_valid_i && bus.wb_rd_wen_i && bus.wb_long_lat_i;
        rel_mask = rel ? (NREG'(1) << bus.wb_rd_idx_i) : '0;
        eff_sb   = sb_q & ~rel_mask;
        cnt_zero = (inflight_q == '0);
        room     = (inflight_q < MAX_C) || bus.wb_valid_i;
        hazard   = (bus.id_rs1_ren_i && (bus.id_rs1_idx_i != 5'd0) && eff_sb[bus.id_rs1_idx_i])
                || (bus.id_rs2_ren_i && (bus.id_rs2_idx_i != 5'd0) && eff_sb[bus.id_rs2_idx_i])
                || (bus.id_rd_wen_i  && (bus.id_rd_idx_i  != 5'd0) && eff_sb[bus.id_rd_idx_i]);
    end

    // Zero-cycle issue decision; serial instructions wait for an empty pipe.
    always_comb begin
        issue_c = 1'b0;
        if (bus.id_valid_i && bus.ex_ready_i && !bus.ex_flush_i && !hazard) begin
            if (bus.id_serial_i) begin
                issue_c = (state_q != ST_SERIAL) && cnt_zero;
            end else begin
                issue_c = (state_q == ST_RUN) && room;
            end
        end
    end

    always_comb begin
        sb_d       = sb_q;
        inflight_d = inflight_q;
        err_d      = err_q;
        state_d    = state_q;
        set_mask   = '0;
        retire     = bus.wb_valid_i && !cnt_zero;

        if (issue_c && bus.id_rd_wen_i && (bus.id_rd_idx_i != 5'd0) && bus.id_long_lat_i) begin
            set_mask = NREG'(1) << bus.id_rd_idx_i;
        end
        sb_d    = eff_sb | set_mask;
        sb_d[0] = 1'b0;

        case ({issue_c, retire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        // Retire with nothing in flight, or release of a register that was never pending.
        if ((bus.wb_valid_i && cnt_zero) || (rel && !sb_q[bus.wb_rd_idx_i])) begin
            err_d = 1'b1;
        end

        // SERIAL deliberately ignores ex_flush_i: the flusher may be the serial instruction.
        case (state_q)
            ST_RUN: begin
                if (issue_c && bus.id_serial_i) begin
                    state_d = ST_SERIAL;
                end else if (bus.id_valid_i && bus.id_serial_i && !bus.ex_flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (issue_c) begin
                    state_d = ST_SERIAL;
                end else if (bus.ex_flush_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_SERIAL: begin
                if (bus.wb_valid_i && (inflight_q == CNT_W'(1))) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            sb_q       <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sb_q       <= sb_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign bus.id_issue_o = issue_c;
    assign bus.id_stall_o = bus.id_valid_i && !issue_c && !bus.ex_flush_i;
    assign bus.sb_busy_o  = sb_q;
    assign bus.inflight_o = inflight_q;
    assign bus.state_o    = state_q;
    assign bus.err_o      = err_q;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: directed scenarios plus random traffic against a pipe-level model.
module tb_id_issue_ctrl;
    localparam int MAXF = 4;
    localparam int M_RUN = 0, M_DRAIN = 1, M_SERIAL = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    id_issue_if bus ();

    id_issue_ctrl #(.MAX_INFLIGHT(MAXF)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Model: pending registers, count of instructions in the pipe, mode, sticky error.
    bit m_pend[32];
    int m_cnt;
    int m_mode;
    bit m_err;

    typedef struct { bit [4:0] rd; bit w; bit ll; } rec_t;
    rec_t pipe_q[$];

    task automatic m_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt  = 0;
        m_mode = M_RUN;
        m_err  = 1'b0;
        pipe_q.delete();
    endtask

    function automatic bit m_blocked(input logic [4:0] r);
        bit released;
        released = bus.wb_valid_i && bus.wb_rd_wen_i && bus.wb_long_lat_i && (bus.wb_rd_idx_i == r);
        return (r != 5'd0) && m_pend[r] && !released;
    endfunction

    function automatic bit m_issue();
        bit haz;
        haz = (bus.id_rs1_ren_i && m_blocked(bus.id_rs1_idx_i))
           || (bus.id_rs2_ren_i && m_blocked(bus.id_rs2_idx_i))
           || (bus.id_rd_wen_i  && m_blocked(bus.id_rd_idx_i));
        if (!bus.id_valid_i || !bus.ex_ready_i || bus.ex_flush_i || haz) return 1'b0;
        if (bus.id_serial_i) return (m_mode != M_SERIAL) && (m_cnt == 0);
        return (m_mode == M_RUN) && ((m_cnt < MAXF) || bus.wb_valid_i);
    endfunction

    function automatic logic [31:0] m_sb();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        bit iss, nx_err;
        bit nx_pend[32];
        int nx_cnt, nx_mode;
        iss     = m_issue();
        nx_pend = m_pend;
        nx_err  = m_err;
        nx_mode = m_mode;
        if (bus.wb_valid_i && bus.wb_rd_wen_i && bus.wb_long_lat_i) begin
            if (!m_pend[bus.wb_rd_idx_i]) nx_err = 1'b1;
            nx_pend[bus.wb_rd_idx_i] = 1'b0;
        end
        if (iss && bus.id_rd_wen_i && bus.id_rd_idx_i != 5'd0 && bus.id_long_lat_i)
            nx_pend[bus.id_rd_idx_i] = 1'b1;
        if (bus.wb_valid_i && m_cnt == 0) nx_err = 1'b1;
        nx_cnt = m_cnt + (iss ? 1 : 0) - ((bus.wb_valid_i && m_cnt > 0) ? 1 : 0);
        if (m_mode == M_RUN) begin
            if (iss && bus.id_serial_i) nx_mode = M_SERIAL;
            else if (bus.id_valid_i && bus.id_serial_i && !bus.ex_flush_i) nx_mode = M_DRAIN;
        end else if (m_mode == M_DRAIN) begin
            if (iss) nx_mode = M_SERIAL;
            else if (bus.ex_flush_i) nx_mode = M_RUN;
        end else begin
            if (bus.wb_valid_i && m_cnt == 1) nx_mode = M_RUN;
        end
        @(posedge clk);
        #1;
        m_pend = nx_pend;
        m_cnt  = nx_cnt;
        m_mode = nx_mode;
        m_err  = nx_err;
    endtask

    task automatic set_id(input bit v, input bit [4:0] rs1, input bit r1, input bit [4:0] rs2,
                          input bit r2, input bit [4:0] rd, input bit w, input bit ll, input bit ser);
        bus.id_valid_i    = v;
        bus.id_rs1_idx_i  = rs1;
        bus.id_rs1_ren_i  = r1;
        bus.id_rs2_idx_i  = rs2;
        bus.id_rs2_ren_i  = r2;
        bus.id_rd_idx_i   = rd;
        bus.id_rd_wen_i   = w;
        bus.id_long_lat_i = ll;
        bus.id_serial_i   = ser;
    endtask

    task automatic set_wb(input bit v, input bit w, input bit ll, input bit [4:0] rd);
        bus.wb_valid_i    = v;
        bus.wb_rd_wen_i   = w;
        bus.wb_long_lat_i = ll;
        bus.wb_rd_idx_i   = rd;
    endtask

    task automatic clear_in();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0, 0);
        bus.ex_ready_i = 1'b1;
        bus.ex_flush_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.sb_busy_o !== 32'h0) begin errors++; $display("FAIL reset_sb got %h exp 0", bus.sb_busy_o); end
        checks++; if (bus.inflight_o !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", bus.inflight_o); end
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
        checks++; if (bus.id_issue_o !== 1'b0) begin errors++; $display("FAIL reset_issue got %b exp 0", bus.id_issue_o); end
    endtask

    task automatic test_load_use();
        clear_in();
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
        #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL lu_load_issue got %b exp 1", bus.id_issue_o); end
        tick();
        checks++; if (bus.sb_busy_o[5] !== 1'b1) begin errors++; $display("FAIL lu_sb_set got %b exp 1", bus.sb_busy_o[5]); end
        set_id(1, 5, 1, 0, 0, 6, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1; checks++; if (bus.id_stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall%0d got %b exp 1", i, bus.id_stall_o); end
            tick();
        end
        set_wb(1, 1, 1, 5);
        #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL lu_release_issue got %b exp 1", bus.id_issue_o); end
        tick();
        checks++; if (bus.sb_busy_o[5] !== 1'b0) begin errors++; $display("FAIL lu_sb_clear got %b exp 0", bus.sb_busy_o[5]); end
        checks++; if (bus.inflight_o !== 3'd1) begin errors++; $display("FAIL lu_inflight got %0d exp 1", bus.inflight_o); end
        clear_in(); set_wb(1, 0, 0, 0); tick(); clear_in();
        checks++; if (bus.inflight_o !== 3'd0) begin errors++; $display("FAIL lu_drain got %0d exp 0", bus.inflight_o); end
    endtask

    task automatic test_x0_waw();
        clear_in();
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 0);
        #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL x0_load_issue got %b exp 1", bus.id_issue_o); end
        tick();
        checks++; if (bus.sb_busy_o !== 32'h0) begin errors++; $display("FAIL x0_sb got %h exp 0", bus.sb_busy_o); end
        set_id(1, 0, 1, 0, 1, 8, 1, 0, 0);
        #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL x0_use_issue got %b exp 1", bus.id_issue_o); end
        tick();
        clear_in(); set_wb(1, 0, 0, 0); tick(); tick(); clear_in();
        set_id(1, 0, 0, 0, 0, 7, 1, 1, 0);
        #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL waw_first_issue got %b exp 1", bus.id_issue_o); end
        tick();
        for (int i = 0; i < 2; i++) begin
            #1; checks++; if (bus.id_stall_o !== 1'b1) begin errors++; $display("FAIL waw_stall%0d got %b exp 1", i, bus.id_stall_o); end
            tick();
        end
        set_wb(1, 1, 1, 7);
        #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL waw_second_issue got %b exp 1", bus.id_issue_o); end
        tick();
        checks++; if (bus.sb_busy_o[7] !== 1'b1) begin errors++; $display("FAIL waw_set_wins got %b exp 1", bus.sb_busy_o[7]); end
        clear_in(); set_wb(1, 1, 1, 7); tick(); clear_in();
        checks++; if (bus.sb_busy_o !== 32'h0) begin errors++; $display("FAIL waw_sb_end got %h exp 0", bus.sb_busy_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL waw_err got %b exp 0", bus.err_o); end
    endtask

    task automatic test_inflight_cap();
        clear_in();
        set_id(1, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < MAXF; i++) begin
            #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL cap_issue%0d got %b exp 1", i, bus.id_issue_o); end
            tick();
        end
        checks++; if (bus.inflight_o !== 3'(MAXF)) begin errors++; $display("FAIL cap_full got %0d exp %0d", bus.inflight_o, MAXF); end
        #1; checks++; if (bus.id_stall_o !== 1'b1) begin errors++; $display("FAIL cap_stall got %b exp 1", bus.id_stall_o); end
        tick();
        set_wb(1, 0, 0, 0);
        #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL cap_retire_issue got %b exp 1", bus.id_issue_o); end
        tick();
        checks++; if (bus.inflight_o !== 3'(MAXF)) begin errors++; $display("FAIL cap_hold got %0d exp %0d", bus.inflight_o, MAXF); end
        clear_in(); set_wb(1, 0, 0, 0);
        for (int i = 0; i < MAXF; i++) tick();
        clear_in();
        checks++; if (bus.inflight_o !== 3'd0) begin errors++; $display("FAIL cap_drain got %0d exp 0", bus.inflight_o); end
    endtask

    task automatic test_serial();
        clear_in();
        set_id(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tick(); tick();
        set_id(1, 3, 1, 0, 0, 10, 1, 1, 1);
        #1; checks++; if (bus.id_stall_o !== 1'b1) begin errors++; $display("FAIL ser_wait_stall got %b exp 1", bus.id_stall_o); end
        tick();
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL ser_drain got %0d exp 1", bus.state_o); end
        set_wb(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1; checks++; if (bus.id_issue_o !== 1'b0) begin errors++; $display("FAIL ser_early%0d got %b exp 0", i, bus.id_issue_o); end
            tick();
        end
        set_wb(0, 0, 0, 0);
        #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL ser_issue got %b exp 1", bus.id_issue_o); end
        tick();
        checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL ser_serial got %0d exp 2", bus.state_o); end
        set_id(1, 11, 1, 0, 0, 12, 1, 0, 0);
        #1; checks++; if (bus.id_stall_o !== 1'b1) begin errors++; $display("FAIL ser_follow_stall got %b exp 1", bus.id_stall_o); end
        tick();
        set_wb(1, 1, 1, 10);
        #1; checks++; if (bus.id_issue_o !== 1'b0) begin errors++; $display("FAIL ser_retire_cycle got %b exp 0", bus.id_issue_o); end
        tick();
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL ser_back_run got %0d exp 0", bus.state_o); end
        set_wb(0, 0, 0, 0);
        #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL ser_follow_issue got %b exp 1", bus.id_issue_o); end
        tick();
        clear_in(); set_wb(1, 0, 0, 0); tick(); clear_in();
    endtask

    task automatic test_flush();
        clear_in();
        set_id(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 2, 1, 1, 1);
        tick();
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL fl_drain got %0d exp 1", bus.state_o); end
        bus.ex_flush_i = 1'b1;
        #1; checks++; if (bus.id_issue_o !== 1'b0 || bus.id_stall_o !== 1'b0) begin errors++; $display("FAIL fl_kill got %b%b exp 00", bus.id_issue_o, bus.id_stall_o); end
        tick();
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL fl_run got %0d exp 0", bus.state_o); end
        clear_in(); set_wb(1, 0, 0, 0); tick(); clear_in();
        set_id(1, 0, 0, 0, 0, 9, 1, 1, 0);
        tick();
        set_wb(1, 1, 1, 9);
        #1; checks++; if (bus.id_issue_o !== 1'b1) begin errors++; $display("FAIL fl_x9_issue got %b exp 1", bus.id_issue_o); end
        tick();
        checks++; if (bus.sb_busy_o[9] !== 1'b1) begin errors++; $display("FAIL fl_x9_set_wins got %b exp 1", bus.sb_busy_o[9]); end
        clear_in(); set_wb(1, 1, 1, 9); tick(); clear_in();
        checks++; if (bus.inflight_o !== 3'd0 || bus.sb_busy_o !== 32'h0) begin errors++; $display("FAIL fl_end got %0d/%h exp 0/0", bus.inflight_o, bus.sb_busy_o); end
    endtask

    task automatic test_error_reset();
        clear_in();
        set_wb(1, 0, 0, 0);
        tick();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", bus.err_o); end
        checks++; if (bus.inflight_o !== 3'd0) begin errors++; $display("FAIL err_inflight got %0d exp 0", bus.inflight_o); end
        clear_in();
        set_id(1, 0, 0, 0, 0, 12, 1, 1, 1);
        tick();
        checks++; if (bus.state_o !== 2'd2 || bus.sb_busy_o[12] !== 1'b1) begin errors++; $display("FAIL err_serial got %0d/%b exp 2/1", bus.state_o, bus.sb_busy_o[12]); end
        clear_in();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL arst_state got %0d exp 0", bus.state_o); end
        checks++; if (bus.sb_busy_o !== 32'h0) begin errors++; $display("FAIL arst_sb got %h exp 0", bus.sb_busy_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", bus.err_o); end
        checks++; if (bus.inflight_o !== 3'd0) begin errors++; $display("FAIL arst_inflight got %0d exp 0", bus.inflight_o); end
        m_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit exp_i, popped;
        clear_in();
        for (int c = 0; c < 600; c++) begin
            set_id($urandom_range(0, 99) < 85,
                   5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom_range(0, 99) < 10);
            bus.ex_ready_i = $urandom_range(0, 99) < 80;
            bus.ex_flush_i = $urandom_range(0, 99) < 5;
            popped = (pipe_q.size() > 0) && ($urandom_range(0, 99) < 40);
            if (popped) set_wb(1, pipe_q[0].w, pipe_q[0].ll, pipe_q[0].rd);
            else        set_wb(0, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)));
            #1;
            exp_i = m_issue();
            checks++; if (bus.id_issue_o !== exp_i) begin errors++; $display("FAIL rnd_issue c%0d got %b exp %b", c, bus.id_issue_o, exp_i); end
            checks++; if (bus.id_stall_o !== (bus.id_valid_i && !exp_i && !bus.ex_flush_i)) begin errors++; $display("FAIL rnd_stall c%0d got %b", c, bus.id_stall_o); end
            if (exp_i) pipe_q.push_back('{rd: bus.id_rd_idx_i, w: bus.id_rd_wen_i && bus.id_rd_idx_i != 5'd0, ll: bus.id_long_lat_i});
            tick();
            if (popped) void'(pipe_q.pop_front());
            checks++; if (bus.sb_busy_o !== m_sb()) begin errors++; $display("FAIL rnd_sb c%0d got %h exp %h", c, bus.sb_busy_o, m_sb()); end
            checks++; if (bus.inflight_o !== 3'(m_cnt)) begin errors++; $display("FAIL rnd_inflight c%0d got %0d exp %0d", c, bus.inflight_o, m_cnt); end
            checks++; if (bus.state_o !== 2'(m_mode)) begin errors++; $display("FAIL rnd_state c%0d got %0d exp %0d", c, bus.state_o, m_mode); end
            checks++; if (bus.err_o !== m_err) begin errors++; $display("FAIL rnd_err c%0d got %b exp %b", c, bus.err_o, m_err); end
        end
        clear_in();
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        m_reset();
        #1;
        test_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        test_load_use();
        test_x0_waw();
        test_inflight_cap();
        test_serial();
        test_flush();
        test_error_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
